// File: rtl/celement_rr_arb_if.sv
// Handshake bundle between the requesters, the round-robin arbiter and the shared C-element stage.
interface celement_rr_arb_if #(
  parameter int NREQ = 4
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] SENDIN;
  logic [NREQ-1:0] EXBIN;
  logic [NREQ-1:0] ACKOUT;
  logic            SENDOUT;
  logic            EXBOUT;
  logic            ACKIN;
  logic            LOPEN;
  logic [GW-1:0]   GNT;
  logic            ERR;

  modport slave (
    input  SENDIN, EXBIN, ACKIN,
    output ACKOUT, SENDOUT, EXBOUT, LOPEN, GNT, ERR
  );

  modport master (
    output SENDIN, EXBIN, ACKIN,
    input  ACKOUT, SENDOUT, EXBOUT, LOPEN, GNT, ERR
  );
endinterface

// File: rtl/celement_rr_arb.sv
// Round-robin arbiter in front of a shared 4-phase C-element stage; async inputs are synchronized.
// Optional SEND watchdog enabled by macro CELEMENT_RR_ARB_TIMEOUT_EN.
module celement_rr_arb #(
  parameter int NREQ        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              CLK,
  input  logic              RESETN,
  celement_rr_arb_if.slave  arb
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || SYNC_STAGES < 2 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("celement_rr_arb: illegal parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_ACKUP = 2'd2
  } state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_send_sync [SYNC_STAGES];
  logic            r_ack_sync  [SYNC_STAGES];
  logic [GW-1:0]   r_last;
  logic [GW-1:0]   r_gnt;
  logic            r_exb;
  logic            r_sendout;
  logic            r_lopen;
  logic [NREQ-1:0] r_ackout;

  logic [NREQ-1:0] w_send_s;
  logic            w_ack_s;
  logic            w_any;
  logic [GW-1:0]   w_next;
  logic [NREQ-1:0] w_gnt_onehot;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        r_send_sync[s] <= '0;
        r_ack_sync[s]  <= 1'b0;
      end
    end else begin
      r_send_sync[0] <= arb.SENDIN;
      r_ack_sync[0]  <= arb.ACKIN;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        r_send_sync[s] <= r_send_sync[s-1];
        r_ack_sync[s]  <= r_ack_sync[s-1];
      end
    end
  end

  assign w_send_s     = r_send_sync[SYNC_STAGES-1];
  assign w_ack_s      = r_ack_sync[SYNC_STAGES-1];
  assign w_gnt_onehot = NREQ'(1) << r_gnt;

  // Search starts one past the last winner, so the most recent grant has lowest priority.
  always_comb begin
    int unsigned idx;
    idx    = 0;
    w_any  = 1'b0;
    w_next = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (int'(r_last) + k) % NREQ;
      if (!w_any && w_send_s[idx]) begin
        w_any  = 1'b1;
        w_next = GW'(idx);
      end
    end
  end

`ifdef CELEMENT_RR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_to_cnt;
  logic          r_err;
  assign arb.ERR = r_err;
`else
  assign arb.ERR = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state   <= S_IDLE;
      r_last    <= GW'(NREQ - 1);
      r_gnt     <= '0;
      r_exb     <= 1'b0;
      r_sendout <= 1'b0;
      r_lopen   <= 1'b0;
      r_ackout  <= '0;
`ifdef CELEMENT_RR_ARB_TIMEOUT_EN
      r_to_cnt  <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any && !w_ack_s) begin
            r_gnt     <= w_next;
            r_exb     <= arb.EXBIN[w_next];
            r_sendout <= 1'b1;
            r_lopen   <= 1'b1;
            r_state   <= S_SEND;
`ifdef CELEMENT_RR_ARB_TIMEOUT_EN
            r_to_cnt  <= '0;
`endif
          end
        end
        S_SEND: begin
          // A requester dropping SENDIN here is a protocol violation and is ignored.
          if (w_ack_s) begin
            r_sendout <= 1'b0;
            r_ackout  <= w_gnt_onehot;
            r_state   <= S_ACKUP;
          end
`ifdef CELEMENT_RR_ARB_TIMEOUT_EN
          else if (r_to_cnt == CW'(TIMEOUT_CYC - 1)) begin
            r_err     <= 1'b1;
            r_sendout <= 1'b0;
            r_ackout  <= w_gnt_onehot;
            r_state   <= S_ACKUP;
          end else begin
            r_to_cnt  <= r_to_cnt + 1'b1;
          end
`endif
        end
        S_ACKUP: begin
          if (!w_send_s[r_gnt] && !w_ack_s) begin
            r_ackout <= '0;
            r_lopen  <= 1'b0;
            r_last   <= r_gnt;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign arb.SENDOUT = r_sendout;
  assign arb.EXBOUT  = r_exb;
  assign arb.LOPEN   = r_lopen;
  assign arb.ACKOUT  = r_ackout;
  assign arb.GNT     = r_gnt;
endmodule

// File: doc/celement_rr_arb.md
CELEMENT_RR_ARB -- requirements
Module: celement_rr_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requester channels (2..8).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flops per input synchronizer (>=2).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255: cycles allowed in SEND before abort (used only with timeout feature).
REQ-004 SHALL have port CLK  input  1  the one clock; all state is rising-edge.
REQ-005 SHALL have port RESETN  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port SENDIN  input  NREQ  per-requester 4-phase request, asynchronous.
REQ-007 SHALL have port EXBIN  input  NREQ  per-requester branch bit, stable while SENDIN[i] high.
REQ-008 SHALL have port ACKOUT  output  NREQ  per-requester acknowledge.
REQ-009 SHALL have port SENDOUT  output  1  request to the shared C-element stage.
REQ-010 SHALL have port EXBOUT  output  1  branch bit of the granted requester.
REQ-011 SHALL have port ACKIN  input  1  acknowledge from the shared stage, asynchronous.
REQ-012 SHALL have port LOPEN  output  1  gate-open enable to the shared stage.
REQ-013 SHALL have port GNT  output  clog2(NREQ)  index of the current/last grant.
REQ-014 SHALL have port ERR  output  1  sticky timeout flag.

Function
REQ-015 SHALL synchronize SENDIN and ACKIN through SYNC_STAGES flops; all decisions use synchronized values.
REQ-016 SHALL implement FSM IDLE, SEND, ACKUP; all outputs registered.
REQ-017 IDLE: SENDOUT=0, LOPEN=0, ACKOUT=0; when any synchronized SENDIN high and synchronized ACKIN low, SHALL choose the first high index searching LAST+1, LAST+2, ... modulo NREQ, load GNT, latch EXBOUT=EXBIN[GNT], go to SEND.
REQ-018 SEND: SENDOUT=1 and LOPEN=1 starting the cycle after the grant decision; on synchronized ACKIN=1 SHALL go to ACKUP.
REQ-019 ACKUP: SENDOUT=0, LOPEN=1, ACKOUT[GNT]=1, all other ACKOUT bits 0.
REQ-020 SHALL leave ACKUP only when synchronized SENDIN[GNT]=0 and synchronized ACKIN=0, then set ACKOUT=0, LOPEN=0, LAST=GNT, and return to IDLE.
REQ-021 SHALL ignore a SENDIN[GNT] drop during SEND (protocol violation); the transaction completes normally.
REQ-022 SHALL ignore requests from non-granted channels until IDLE; no request is lost, because each requester holds SENDIN until acknowledged.
REQ-023 Simultaneous requests SHALL resolve by round-robin only; no index has fixed priority.
REQ-024 EXBOUT and GNT SHALL hold their values from the grant until the next grant.
REQ-025 Minimum transaction SHALL be 3 FSM cycles plus synchronizer latency; back-to-back grants to different requesters SHALL be possible with one IDLE cycle between them.

Reset
REQ-026 On RESETN=0, SHALL enter IDLE immediately, asynchronously; reset values: SENDOUT=0, LOPEN=0, ACKOUT=0, EXBOUT=0, GNT=0, ERR=0, LAST=NREQ-1, synchronizers 0.
REQ-027 Reset mid-transaction SHALL drop SENDOUT and ACKOUT at once; the first post-reset grant SHALL search from index 0.

Configuration
REQ-028 With macro CELEMENT_RR_ARB_TIMEOUT_EN defined: SHALL count cycles in SEND; when the count reaches TIMEOUT_CYC, SHALL set ERR=1 (sticky until reset), drop SENDOUT, and go to ACKUP, acknowledging the requester.
REQ-029 Without CELEMENT_RR_ARB_TIMEOUT_EN: SHALL include no counter, tie ERR to 0, and keep SEND waiting indefinitely.

Verification
REQ-030 Single request: SENDIN=0001, EXBIN=0001 -> GNT=0, EXBOUT=1, SENDOUT rises; ACKIN=1 -> ACKOUT=0001, SENDOUT=0; SENDIN=0, ACKIN=0 -> ACKOUT=0000, IDLE.
REQ-031 Round-robin: SENDIN=1111 held, each handshake completed -> GNT sequence 0,1,2,3,0.
REQ-032 Fairness after last=1: SENDIN=0101 -> GNT=2 next, then 0.
REQ-033 Reset mid-SEND: RESETN low with SENDOUT=1 -> SENDOUT=0, ACKOUT=0000 within the same cycle; after release, SENDIN=1000 -> GNT=3.
REQ-034 Timeout (macro on, TIMEOUT_CYC=8): grant with ACKIN held 0 -> after 8 SEND cycles ERR=1, SENDOUT=0, ACKOUT[GNT]=1; macro off -> SENDOUT stays 1 and ERR stays 0.
REQ-035 Non-granted requester drop: SENDIN=0011 with grant on 0; pulse SENDIN[1] off/on during SEND -> no ACKOUT[1] until its own grant.
